// File: rtl/mux_arbiter_2to1.sv
// Two-source valid/ready arbiter feeding a single registered output stage.
// Contention is resolved round-robin by a two-state priority FSM.
module mux_arbiter_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e state, state_nxt;
  logic  load_en, grant_a, grant_b;

  // Output register may be refilled when empty or drained this cycle.
  assign load_en = !y_valid || y_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PRIO_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (grant_a)      state_nxt = PRIO_B;
    else if (grant_b) state_nxt = PRIO_A;
  end

  // Grants never look at y_valid through a source's own ready, so no loops.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && load_en) begin
      if (a_valid && (!b_valid || state == PRIO_A)) grant_a = 1'b1;
      else if (b_valid)                             grant_b = 1'b1;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      sel     <= 1'b0;
    end else if (load_en) begin
      if (grant_a) begin
        y_valid <= 1'b1;
        y_data  <= a_data;
        sel     <= 1'b0;
      end else if (grant_b) begin
        y_valid <= 1'b1;
        y_data  <= b_data;
        sel     <= 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Bench for mux_arbiter_2to1: directed vector table, async-reset sequences,
// and a randomized run against a one-slot buffer / round-robin model.
module tb_mux_arbiter_2to1;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, y_valid, sel;
  logic [7:0] y_data;

  int n_checks = 0;
  int n_pass   = 0;

  mux_arbiter_2to1 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       yr;
    logic       ar_e;
    logic       br_e;
    logic       yv_e;
    logic [7:0] yd_e;
    logic       sel_e;
  } vec_t;

  typedef struct {
    logic       s;
    logic [7:0] d;
  } word_t;

  vec_t  tbl [17];
  word_t sb_q[$];

  function automatic vec_t mk(logic av, logic [7:0] ad, logic bv, logic [7:0] bd, logic yr,
                              logic ar, logic br, logic yv, logic [7:0] yd, logic s);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.yr = yr;
    v.ar_e = ar; v.br_e = br; v.yv_e = yv; v.yd_e = yd; v.sel_e = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic yr);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
  endtask

  initial begin
    logic       pref_a, can_load, ea, eb, av, bv, yr;
    logic [7:0] ad, bd;
    word_t      w;

    // Contention, alternation, drain, B-only, stall, empty-with-y_ready=0
    tbl[0]  = mk(1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 0);
    tbl[1]  = mk(1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 1);
    tbl[2]  = mk(1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 0);
    tbl[3]  = mk(1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 1);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h22, 1);
    tbl[5]  = mk(0, 8'h00, 1, 8'h5A, 1,  0, 1,  1, 8'h5A, 1);
    tbl[6]  = mk(1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 0);
    tbl[7]  = mk(1, 8'h33, 1, 8'h44, 0,  0, 0,  1, 8'h11, 0);
    tbl[8]  = mk(1, 8'h33, 1, 8'h44, 0,  0, 0,  1, 8'h11, 0);
    tbl[9]  = mk(1, 8'h33, 1, 8'h44, 0,  0, 0,  1, 8'h11, 0);
    tbl[10] = mk(1, 8'h33, 1, 8'h44, 1,  0, 1,  1, 8'h44, 1);
    tbl[11] = mk(1, 8'h55, 0, 8'h00, 0,  0, 0,  1, 8'h44, 1);
    tbl[12] = mk(1, 8'h66, 0, 8'h00, 1,  1, 0,  1, 8'h66, 0);
    tbl[13] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0,  1, 8'h66, 0);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h66, 0);
    tbl[15] = mk(1, 8'h77, 0, 8'h00, 0,  1, 0,  1, 8'h77, 0);
    tbl[16] = mk(1, 8'h88, 0, 8'h00, 0,  0, 0,  1, 8'h77, 0);

    // Reset state, with both sources requesting
    rst = 1'b1;
    drive(1, 8'hAA, 1, 8'hBB, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data",  y_data, 0);
    check("rst_sel",     sel, 0);
    check("rst_readies", {a_ready, b_ready}, 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].yr);
      #2;
      check($sformatf("vec%0d_readies", i), {a_ready, b_ready}, {tbl[i].ar_e, tbl[i].br_e});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out", i), {y_valid, sel, y_data},
            {tbl[i].yv_e, tbl[i].sel_e, tbl[i].yd_e});
    end

    // Async reset between edges while holding 0x77 with B preferred
    drive(0, 8'h00, 0, 8'h00, 0);
    #2;
    check("pre_async_y_valid", y_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_out", {y_valid, sel, y_data}, 0);
    #1 rst = 1'b0;
    drive(1, 8'hC1, 1, 8'hC2, 1);
    #1;
    check("post_rst_prio_a", {a_ready, b_ready}, 2'b10);
    @(posedge clk);
    #1;
    check("post_rst_out", {y_valid, sel, y_data}, {1'b1, 1'b0, 8'hC1});

    // Randomized run against a one-slot buffer with round-robin preference
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    pref_a = 1'b1;
    sb_q.delete();
    for (int c = 0; c < 10000; c++) begin
      av = ($urandom_range(0, 9) < 6);
      bv = ($urandom_range(0, 9) < 6);
      yr = ($urandom_range(0, 9) < 7);
      ad = 8'($urandom);
      bd = 8'($urandom);
      drive(av, ad, bv, bd, yr);
      #1;
      can_load = (sb_q.size() == 0) || yr;
      ea = can_load && av && (!bv || pref_a);
      eb = can_load && bv && (!av || !pref_a);
      check("rnd_y_valid", y_valid, (sb_q.size() != 0));
      check("rnd_readies", {a_ready, b_ready}, {ea, eb});
      if (a_ready && b_ready) check("rnd_both_ready", 1, 0);
      if (yr && sb_q.size() != 0) begin
        w = sb_q.pop_front();
        check("rnd_word", {sel, y_data}, {w.s, w.d});
      end
      if (ea) begin
        w.s = 1'b0; w.d = ad; sb_q.push_back(w); pref_a = 1'b0;
      end else if (eb) begin
        w.s = 1'b1; w.d = bd; sb_q.push_back(w); pref_a = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_2to1.md
MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the data width of both sources and the output.
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004: a_valid  input  1  SHALL flag that source A offers a word.
REQ-005: a_data  input  WIDTH  SHALL be source A's word.
REQ-006: a_ready  output  1  SHALL flag that source A's word is accepted this cycle.
REQ-007: b_valid, b_data, b_ready SHALL mirror the A ports for source B (widths 1, WIDTH, 1).
REQ-008: y_valid  output  1  SHALL flag that the output register holds a word.
REQ-009: y_data  output  WIDTH  SHALL be the registered output word.
REQ-010: y_ready  input  1  SHALL flag that the consumer takes y_data this cycle.
REQ-011: sel  output  1  SHALL give the source of the current y_data (0 = A, 1 = B), registered with y_data.

Function
REQ-012: A transfer on any port SHALL occur only in a cycle where its valid and ready are both 1 at the rising edge.
REQ-013: load_en SHALL be (!y_valid || y_ready); no source SHALL be granted when load_en = 0.
REQ-014: Priority FSM SHALL have two states, PRIO_A and PRIO_B, naming the source preferred on contention.
REQ-015: If load_en and exactly one of a_valid/b_valid is 1, that source SHALL be granted regardless of FSM state.
REQ-016: If load_en and both valid, the FSM-preferred source SHALL be granted.
REQ-017: After any grant the FSM SHALL move to prefer the other source (grant A -> PRIO_B, grant B -> PRIO_A).
REQ-018: Without a grant, the FSM state SHALL be unchanged.
REQ-019: a_ready/b_ready SHALL be combinational: 1 only for the granted source in that cycle, never both 1.
REQ-020: readies SHALL NOT depend on their own source's valid only through combinational loops; y_ready -> ready path permitted.
REQ-021: On a grant, y_data and sel SHALL load the granted word/source and y_valid SHALL be 1 next cycle (latency 1).
REQ-022: If load_en and no source valid, y_valid SHALL go 0 next cycle; y_data and sel SHALL hold.
REQ-023: Stall (y_valid = 1, y_ready = 0): y_valid, y_data, sel and FSM SHALL hold; both readies 0.
REQ-024: Throughput SHALL be one word per cycle when y_ready stays 1 and any source is valid.
REQ-025: Sustained contention with y_ready = 1 SHALL alternate grants A, B, A, B, ...; no source waits more than one grant.

Reset
REQ-026: While rst = 1: y_valid = 0, y_data = 0, sel = 0, FSM = PRIO_A, a_ready = b_ready = 0.
REQ-027: Reset asserted mid-operation SHALL discard the held output word immediately, without waiting for clk.
REQ-028: First grant after reset release SHALL follow REQ-015/016 with FSM in PRIO_A.

Verification
REQ-029: Reset, then a_valid = b_valid = 1, a_data = 0x11, b_data = 0x22, y_ready = 1 for 4 cycles -> y_data 0x11, 0x22, 0x11, 0x22 with sel 0, 1, 0, 1.
REQ-030: Only b_valid = 1, b_data = 0x5A, y_ready = 1 -> b_ready = 1, next cycle y_valid = 1, y_data = 0x5A, sel = 1; FSM = PRIO_A.
REQ-031: y_valid = 1 holding 0x11, y_ready = 0 for 3 cycles with both sources valid -> a_ready = b_ready = 0, y_data stays 0x11, on release next grant = B.
REQ-032: y_valid = 1, y_ready = 1, no source valid -> y_valid = 0 next cycle, y_data unchanged.
REQ-033: rst pulsed between clock edges while y_valid = 1 -> y_valid, y_data, sel go 0 before the next edge; FSM = PRIO_A.
REQ-034: Random valid/ready stimulus 10000 cycles -> scoreboard: every accepted word appears once, in acceptance order, with correct sel; never both readies 1.
